// File: rtl/fir_tdm_mac_sched_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR stages.
// Provides the scheduler state encoding, the accumulator width rule and the Q15 saturation rule.
package fir_sched_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int PRODUCT_WIDTH = 2 * DATA_WIDTH;
  localparam int MAX_TAPS      = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    SAT,
    OUT
  } state_t;

  // Guard bits make NUM_TAPS full-scale products fit without wrapping.
  function automatic int acc_width(input int n);
    return PRODUCT_WIDTH + $clog2(n) + 1;
  endfunction

  localparam int ACC_MAX_W = acc_width(MAX_TAPS);

  localparam logic signed [ACC_MAX_W-1:0] Q15_MAX = ACC_MAX_W'(32767);
  localparam logic signed [ACC_MAX_W-1:0] Q15_MIN = ACC_MAX_W'(-32768);

  // Callers sign-extend their accumulator to ACC_MAX_W before calling.
  function automatic logic [DATA_WIDTH-1:0] sat_q15(input logic signed [ACC_MAX_W-1:0] acc);
    logic signed [ACC_MAX_W-1:0] y;
    y = acc >>> 15;
    if (y > Q15_MAX) begin
      return 16'h7fff;
    end else if (y < Q15_MIN) begin
      return 16'h8000;
    end
    return y[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fir_tdm_mac_sched_if.sv
// Sample, result and coefficient-host signals of the FIR MAC scheduler.
// The master side is the sample source / host / consumer; the slave side is the scheduler.
interface fir_tdm_mac_sched_if #(
  parameter int NUM_TAPS = 16
);
  import fir_sched_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          coef_we;
  logic [$clog2(NUM_TAPS)-1:0]   coef_addr;
  logic [DATA_WIDTH-1:0]         coef_data;
  logic                          cfg_err;
  logic                          clr_hist;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          busy;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, clr_hist, out_ready,
    input  in_ready, cfg_err, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, clr_hist, out_ready,
    output in_ready, cfg_err, out_valid, out_data, busy
  );

endinterface

// File: rtl/fir_tdm_mac_sched_coef_bank.sv
// Coefficient register file: one synchronous write port, one combinational read port.
// Held in flops so the whole bank clears on reset.
module fir_coef_bank
  import fir_sched_pkg::*;
#(
  parameter int NUM_TAPS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic [$clog2(NUM_TAPS)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic [$clog2(NUM_TAPS)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]       rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_TAPS];

  // NOTE: the bank is built from flops rather than a RAM macro, so every entry can take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_tdm_mac_sched.sv
// Time-division FIR scheduler: one multiplier and one accumulator walk NUM_TAPS taps per accepted
// sample, then the Q15-scaled, saturated result is offered on a valid/ready output.
module fir_tdm_mac_sched
  import fir_sched_pkg::*;
#(
  parameter int NUM_TAPS = 16,
  parameter int ACC_W    = acc_width(NUM_TAPS)
) (
  input  logic               clk,
  input  logic               rst,
  fir_tdm_mac_sched_if.slave bus
);

  localparam int AW = $clog2(NUM_TAPS);
  localparam logic [AW-1:0] K_LAST = AW'(NUM_TAPS - 1);

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0]    hist_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]    sample_q;
  logic [AW-1:0]                   wr_ptr_q;
  logic [AW-1:0]                   k_q;
  logic signed [ACC_W-1:0]         acc_q;
  logic [DATA_WIDTH-1:0]           out_data_q;
  logic                            cfg_err_q;

  logic                            idle;
  logic                            accept;
  logic [AW-1:0]                   rd_idx;
  logic signed [DATA_WIDTH-1:0]    coef_rd;
  logic signed [PRODUCT_WIDTH-1:0] product;
  logic signed [ACC_W-1:0]         product_ext;
  logic                            in_ready;
  logic                            out_valid;
  logic                            busy;

  assign idle   = (state_q == IDLE);
  assign accept = bus.in_valid && in_ready;

  // Newest sample sits at wr_ptr; tap k reaches k samples back, wrapping modulo the power-of-2 depth.
  assign rd_idx      = wr_ptr_q - k_q;
  assign product     = hist_q[rd_idx] * coef_rd;
  assign product_ext = {{(ACC_W - PRODUCT_WIDTH){product[PRODUCT_WIDTH-1]}}, product};

  fir_coef_bank #(
    .NUM_TAPS (NUM_TAPS)
  ) u_coef_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.coef_we && idle),
    .waddr_i (bus.coef_addr),
    .wdata_i (bus.coef_data),
    .raddr_i (k_q),
    .rdata_o (coef_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = idle && !rst;
    out_valid = (state_q == OUT);
    busy      = !idle;
    case (state_q)
      IDLE:    if (bus.in_valid)   state_d = LOAD;
      LOAD:                        state_d = MAC;
      MAC:     if (k_q == K_LAST)  state_d = SAT;
      SAT:                         state_d = OUT;
      OUT:     if (bus.out_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) hist_q[i] <= '0;
      sample_q   <= '0;
      wr_ptr_q   <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= bus.coef_we && !idle;
      case (state_q)
        IDLE: begin
          if (bus.clr_hist) begin
            for (int i = 0; i < NUM_TAPS; i++) hist_q[i] <= '0;
            wr_ptr_q <= '0;
          end
          if (accept) sample_q <= bus.in_data;
        end
        LOAD: begin
          hist_q[wr_ptr_q] <= sample_q;
          acc_q            <= '0;
          k_q              <= '0;
        end
        MAC: begin
          acc_q <= acc_q + product_ext;
          k_q   <= k_q + 1'b1;
        end
        SAT: out_data_q <= sat_q15(ACC_MAX_W'(acc_q));
        OUT: if (bus.out_ready) wr_ptr_q <= wr_ptr_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.out_data  = out_data_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fir_tdm_mac_sched.sv
// Directed bench for fir_tdm_mac_sched: impulse, saturation, back-pressure, config-while-busy,
// pointer wrap with history clear, back-to-back timing and reset during MAC.
module tb_fir_tdm_mac_sched;

  localparam int N  = 16;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   last_lat = 0;

  fir_tdm_mac_sched_if #(.NUM_TAPS(N)) bus ();

  fir_tdm_mac_sched #(.NUM_TAPS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [AW-1:0] addr, input logic [15:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr;
    bus.coef_data = data;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic set_all_coefs(input logic [15:0] data);
    for (int k = 0; k < N; k++) write_coef(AW'(k), data);
  endtask

  task automatic set_impulse_coefs();
    for (int k = 0; k < N; k++) write_coef(AW'(k), 16'(k * 256));
  endtask

  task automatic clear_hist();
    bus.clr_hist = 1'b1;
    tick();
    bus.clr_hist = 1'b0;
  endtask

  // Offers one sample (optionally with clr_hist in the accept cycle), waits for and consumes the result.
  task automatic run_sample(input logic [15:0] x, input bit with_clear, output logic [15:0] y);
    int cyc;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.clr_hist = with_clear;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.clr_hist = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    last_lat = cyc + 1;
    y = bus.out_data;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1 within 200 cycles", bus.out_valid);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cfg_err, bus.out_data} !== 20'h0) begin
      errors++;
      $display("FAIL reset_during: in_ready=%b out_valid=%b busy=%b cfg_err=%b out_data=%h required all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.cfg_err, bus.out_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b required 1/0", bus.in_ready, bus.busy);
    end
    tick();
  endtask

  task automatic test_impulse(input string tag, input bit clear_with_first);
    logic [15:0] y, exp_y;
    set_impulse_coefs();
    if (!clear_with_first) clear_hist();
    for (int n = 0; n < N; n++) begin
      run_sample((n == 0) ? 16'h7fff : 16'h0000, clear_with_first && (n == 0), y);
      exp_y = (n == 0) ? 16'h0000 : 16'(n * 256 - 1);
      checks++;
      if (y !== exp_y) begin
        errors++;
        $display("FAIL %s[%0d]: got %h required %h", tag, n, y, exp_y);
      end
      if (n == 0) begin
        checks++;
        if (last_lat != N + 3) begin
          errors++;
          $display("FAIL %s_latency: got %0d required %0d", tag, last_lat, N + 3);
        end
      end
    end
  endtask

  task automatic sat_case(input string tag, input logic [15:0] h, input logic [15:0] x,
                          input logic [15:0] exp_first, input logic [15:0] exp_last);
    logic [15:0] y;
    set_all_coefs(h);
    clear_hist();
    for (int n = 0; n < N; n++) begin
      run_sample(x, 1'b0, y);
      if (n == 0 || n == N - 1) begin
        checks++;
        if (y !== ((n == 0) ? exp_first : exp_last)) begin
          errors++;
          $display("FAIL %s[%0d]: got %h required %h", tag, n, y, (n == 0) ? exp_first : exp_last);
        end
      end
    end
  endtask

  task automatic test_saturation();
    sat_case("sat_pos",  16'h7fff, 16'h7fff, 16'h7ffe, 16'h7fff);
    sat_case("sat_neg",  16'h7fff, 16'h8000, 16'h8001, 16'h8000);
    sat_case("sat_full", 16'h8000, 16'h8000, 16'h7fff, 16'h7fff);
  endtask

  // Coefficients are all 16'h8000 here: 0x2000 * -32768 >>> 15 = -8192.
  task automatic test_backpressure();
    int cyc, xfers;
    clear_hist();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h2000;
    tick();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.busy, bus.out_data} !== {3'b101, 16'he000}) begin
        errors++;
        $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b busy=%b out_data=%h required 1/0/1/e000",
                 i, bus.out_valid, bus.in_ready, bus.busy, bus.out_data);
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    xfers = 0;
    repeat (3) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) xfers++;
      tick();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (xfers != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: transfers=%0d busy=%b required 1/0", xfers, bus.busy);
    end
  endtask

  // Coefficients still 16'h8000: A=0x2000 then B=0xe000 gives B*h0 + A*h1 = 2^28 - 2^28 = 0.
  task automatic test_back_to_back();
    int cyc;
    logic [15:0] y;
    clear_hist();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h2000;
    tick();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'he000;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b in_ready=%b out_valid=%b required 0/1/0",
               bus.busy, bus.in_ready, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.busy, bus.in_ready} !== 2'b10 || cyc + 2 != N + 4) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b in_ready=%b period=%0d required 1/0/%0d",
               bus.busy, bus.in_ready, cyc + 2, N + 4);
    end
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    y = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (y !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_result: got %h required 0000", y);
    end
  endtask

  task automatic test_cfg_busy();
    int cyc;
    logic [15:0] y;
    set_all_coefs(16'h0000);
    write_coef('0, 16'h4000);
    clear_hist();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1000;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    write_coef('0, 16'h7fff);
    checks++;
    if (bus.cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_pulse: got %b required 1", bus.cfg_err);
    end
    tick();
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_single: got %b required 0", bus.cfg_err);
    end
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    y = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (y !== 16'd500) begin
      errors++;
      $display("FAIL cfg_busy_ignored: got %0d required 500", y);
    end
    write_coef('0, 16'h7fff);
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_idle: got %b required 0", bus.cfg_err);
    end
    clear_hist();
    run_sample(16'd1000, 1'b0, y);
    checks++;
    if (y !== 16'd999) begin
      errors++;
      $display("FAIL cfg_idle_applied: got %0d required 999", y);
    end
  endtask

  task automatic test_wrap_clear();
    int hk [N];
    int xs [2*N+3];
    longint acc;
    logic [15:0] y, exp_y;
    for (int k = 0; k < N; k++) begin
      hk[k] = ((k * 1237) % 4001) - 2000;
      write_coef(AW'(k), 16'(hk[k]));
    end
    for (int i = 0; i < 2*N+3; i++) xs[i] = ((i * 7919) % 20001) - 10000;
    clear_hist();
    for (int n = 0; n < 2*N+3; n++) begin
      run_sample(16'(xs[n]), 1'b0, y);
      acc = 0;
      for (int k = 0; k < N; k++) if (n - k >= 0) acc += longint'(xs[n-k]) * longint'(hk[k]);
      acc = acc >>> 15;
      exp_y = (acc > 32767) ? 16'h7fff : (acc < -32768) ? 16'h8000 : 16'(acc);
      checks++;
      if (y !== exp_y) begin
        errors++;
        $display("FAIL wrap[%0d]: got %h required %h", n, y, exp_y);
      end
    end
    test_impulse("post_clear", 1'b1);
  endtask

  task automatic test_reset_mid_mac();
    logic [15:0] y;
    set_impulse_coefs();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7fff;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_mac: out_valid=%b busy=%b in_ready=%b required 0/0/0",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy, bus.cfg_err, bus.out_data} !== {3'b100, 16'h0000}) begin
      errors++;
      $display("FAIL rst_mid_mac_release: in_ready=%b busy=%b cfg_err=%b out_data=%h required 1/0/0/0000",
               bus.in_ready, bus.busy, bus.cfg_err, bus.out_data);
    end
    tick();
    for (int n = 0; n < 3; n++) begin
      run_sample((n == 0) ? 16'h7fff : 16'h0000, 1'b0, y);
      checks++;
      if (y !== 16'h0000) begin
        errors++;
        $display("FAIL rst_zero_coef[%0d]: got %h required 0000", n, y);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.clr_hist  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_impulse("impulse", 1'b0);
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_cfg_busy();
    test_wrap_clear();
    test_reset_mid_mac();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
